atm_host_responder: RTL

//  Bank-host side of the ATM transaction link. Accepts one request at a time from the ATM

---
 rtl/atm_pkg.sv | 33 +++
 rtl/atm_host_responder_if.sv | 28 ++
 rtl/atm_ledger.sv | 60 ++++++
 rtl/atm_host_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared definitions for the ATM bank-host responder: opcodes, status codes,
// FSM states and the factory PIN.
package atm_pkg;

    localparam int          PIN_W           = 4;
    localparam logic [3:0]  ATM_DEFAULT_PIN = 4'b1010;

    // Request opcodes; encodings 5-7 are illegal.
    localparam logic [2:0]  OP_LOGIN    = 3'd0;
    localparam logic [2:0]  OP_BALANCE  = 3'd1;
    localparam logic [2:0]  OP_DEPOSIT  = 3'd2;
    localparam logic [2:0]  OP_WITHDRAW = 3'd3;
    localparam logic [2:0]  OP_LOGOUT   = 3'd4;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_BAD_PIN      = 3'd1,
        ST_LOCKED       = 3'd2,
        ST_NO_SESSION   = 3'd3,
        ST_INSUFFICIENT = 3'd4,
        ST_OVERFLOW     = 3'd5,
        ST_BAD_ACCT     = 3'd6,
        ST_BAD_OP       = 3'd7
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_EXEC  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/atm_host_responder_if.sv
// Request/response channel between the ATM controller (master) and the
// bank-host responder (slave).
interface atm_host_responder_if #(
    parameter int ACCT_W = 3,
    parameter int AMT_W  = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ACCT_W-1:0] req_acct;
    logic [3:0]        req_pin;
    logic [AMT_W-1:0]  req_amount;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [AMT_W-1:0]  rsp_balance;
    logic              sess_active;

    modport master (
        output req_valid, req_op, req_acct, req_pin, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance, sess_active
    );

    modport slave (
        input  req_valid, req_op, req_acct, req_pin, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance, sess_active
    );
endinterface

// File: rtl/atm_ledger.sv
// Account ledger: balance, PIN, wrong-PIN counter and lock flag per account.
// Combinational read port, single synchronous write port.
module atm_ledger
    import atm_pkg::*;
#(
    parameter int          NUM_ACCTS    = 8,
    parameter int          ACCT_W       = 3,
    parameter int          AMT_W        = 32,
    parameter int unsigned INIT_BALANCE = 1000000,
    parameter logic [3:0]  DEFAULT_PIN  = ATM_DEFAULT_PIN,
    parameter int          TRIES_W      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ACCT_W-1:0]  rd_idx,
    output logic [AMT_W-1:0]   rd_balance,
    output logic [PIN_W-1:0]   rd_pin,
    output logic [TRIES_W-1:0] rd_tries,
    output logic               rd_locked,
    input  logic               wr_en,
    input  logic [ACCT_W-1:0]  wr_idx,
    input  logic [AMT_W-1:0]   wr_balance,
    input  logic [TRIES_W-1:0] wr_tries,
    input  logic               wr_locked
);

    logic [AMT_W-1:0]   balance_r [NUM_ACCTS];
    logic [PIN_W-1:0]   pin_r     [NUM_ACCTS];
    logic [TRIES_W-1:0] tries_r   [NUM_ACCTS];
    logic               locked_r  [NUM_ACCTS];

    logic rd_ok;
    logic wr_ok;

    // Indices beyond the populated accounts read as zero and never write.
    assign rd_ok = ({1'b0, rd_idx} < (ACCT_W+1)'(NUM_ACCTS));
    assign wr_ok = ({1'b0, wr_idx} < (ACCT_W+1)'(NUM_ACCTS));

    assign rd_balance = rd_ok ? balance_r[rd_idx] : '0;
    assign rd_pin     = rd_ok ? pin_r[rd_idx]     : '0;
    assign rd_tries   = rd_ok ? tries_r[rd_idx]   : '0;
    assign rd_locked  = rd_ok ? locked_r[rd_idx]  : 1'b0;

    // Ledger storage: factory values on reset, one account updated per write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                balance_r[i] <= AMT_W'(INIT_BALANCE);
                pin_r[i]     <= DEFAULT_PIN;
                tries_r[i]   <= '0;
                locked_r[i]  <= 1'b0;
            end
        end else if (wr_en && wr_ok) begin
            balance_r[wr_idx] <= wr_balance;
            tries_r[wr_idx]   <= wr_tries;
            locked_r[wr_idx]  <= wr_locked;
        end
    end

endmodule

// File: rtl/atm_host_responder.sv
// Bank-host responder: accepts one ATM request at a time, classifies it
// against the session and ledger, commits a single ledger write and
// returns status plus the session balance.
module atm_host_responder
    import atm_pkg::*;
#(
    parameter int          NUM_ACCTS    = 8,
    parameter int          ACCT_W       = 3,
    parameter int          AMT_W        = 32,
    parameter int unsigned INIT_BALANCE = 1000000,
    parameter logic [3:0]  DEFAULT_PIN  = ATM_DEFAULT_PIN,
    parameter int          MAX_TRIES    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    atm_host_responder_if.slave  bus
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    state_e state_q, state_d;

    // Captured request
    logic [2:0]        op_q;
    logic [ACCT_W-1:0] acct_q;
    logic [PIN_W-1:0]  pin_q;
    logic [AMT_W-1:0]  amt_q;

    // Session and response
    logic              sess_q;
    logic [ACCT_W-1:0] sess_acct_q;
    status_e           rsp_status_q;
    logic [AMT_W-1:0]  rsp_balance_q;

    // Ledger read port
    logic [ACCT_W-1:0]  rd_idx;
    logic [AMT_W-1:0]   rd_balance;
    logic [PIN_W-1:0]   rd_pin;
    logic [TRIES_W-1:0] rd_tries;
    logic               rd_locked;

    // Classification result (combinational in CHECK, registered for EXEC)
    status_e            c_status, plan_status;
    logic               c_wr, plan_wr;
    logic [AMT_W-1:0]   c_bal, plan_bal;
    logic [TRIES_W-1:0] c_tries, plan_tries;
    logic               c_locked, plan_locked;
    logic               c_sess, plan_sess;
    logic [ACCT_W-1:0]  c_sacct, plan_sacct;
    logic [AMT_W-1:0]   c_rbal, plan_rbal;
    logic [ACCT_W-1:0]  plan_idx;

    logic [AMT_W:0]     dep_sum;
    logic               bad_acct;

    function automatic logic [AMT_W:0] wide_add(input logic [AMT_W-1:0] a,
                                                input logic [AMT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    atm_ledger #(
        .NUM_ACCTS    (NUM_ACCTS),
        .ACCT_W       (ACCT_W),
        .AMT_W        (AMT_W),
        .INIT_BALANCE (INIT_BALANCE),
        .DEFAULT_PIN  (DEFAULT_PIN),
        .TRIES_W      (TRIES_W)
    ) u_ledger (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (rd_idx),
        .rd_balance (rd_balance),
        .rd_pin     (rd_pin),
        .rd_tries   (rd_tries),
        .rd_locked  (rd_locked),
        .wr_en      (state_q == S_EXEC && plan_wr),
        .wr_idx     (plan_idx),
        .wr_balance (plan_bal),
        .wr_tries   (plan_tries),
        .wr_locked  (plan_locked)
    );

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_status  = rsp_status_q;
    assign bus.rsp_balance = rsp_balance_q;
    assign bus.sess_active = sess_q;

    assign rd_idx   = (op_q == OP_LOGIN) ? acct_q : sess_acct_q;
    assign dep_sum  = wide_add(rd_balance, amt_q);
    assign bad_acct = ({1'b0, acct_q} >= (ACCT_W+1)'(NUM_ACCTS));

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: one cycle each for CHECK and EXEC, RESP waits for rsp_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = S_CHECK;
            S_CHECK: state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture on accept
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.req_valid) begin
            op_q   <= bus.req_op;
            acct_q <= bus.req_acct;
            pin_q  <= bus.req_pin;
            amt_q  <= bus.req_amount;
        end
    end

    // Classify the captured request against session and ledger state
    always_comb begin
        c_status = ST_OK;
        c_wr     = 1'b0;
        c_bal    = rd_balance;
        c_tries  = rd_tries;
        c_locked = rd_locked;
        c_sess   = sess_q;
        c_sacct  = sess_acct_q;
        c_rbal   = sess_q ? rd_balance : '0;
        case (op_q)
            OP_LOGIN: begin
                // Any open session is dropped before the PIN is checked.
                c_sess = 1'b0;
                c_rbal = '0;
                if (bad_acct) begin
                    c_status = ST_BAD_ACCT;
                end else if (rd_locked) begin
                    c_status = ST_LOCKED;
                end else if (pin_q != rd_pin) begin
                    c_wr    = 1'b1;
                    c_tries = rd_tries + 1'b1;
                    if (c_tries >= TRIES_W'(MAX_TRIES)) begin
                        c_locked = 1'b1;
                        c_status = ST_LOCKED;
                    end else begin
                        c_status = ST_BAD_PIN;
                    end
                end else begin
                    c_wr    = 1'b1;
                    c_tries = '0;
                    c_sess  = 1'b1;
                    c_sacct = acct_q;
                    c_rbal  = rd_balance;
                end
            end
            OP_BALANCE, OP_DEPOSIT, OP_WITHDRAW, OP_LOGOUT: begin
                if (!sess_q) begin
                    c_status = ST_NO_SESSION;
                end else if (op_q == OP_DEPOSIT) begin
                    if (dep_sum[AMT_W]) begin
                        c_status = ST_OVERFLOW;
                    end else begin
                        c_wr   = 1'b1;
                        c_bal  = dep_sum[AMT_W-1:0];
                        c_rbal = dep_sum[AMT_W-1:0];
                    end
                end else if (op_q == OP_WITHDRAW) begin
                    if (amt_q > rd_balance) begin
                        c_status = ST_INSUFFICIENT;
                    end else begin
                        c_wr   = 1'b1;
                        c_bal  = rd_balance - amt_q;
                        c_rbal = rd_balance - amt_q;
                    end
                end else if (op_q == OP_LOGOUT) begin
                    c_sess = 1'b0;
                    c_rbal = '0;
                end
            end
            default: c_status = ST_BAD_OP;
        endcase
    end

    // CHECK -> EXEC boundary: hold the classification for the commit cycle
    always_ff @(posedge clk) begin
        if (state_q == S_CHECK) begin
            plan_status <= c_status;
            plan_wr     <= c_wr;
            plan_bal    <= c_bal;
            plan_tries  <= c_tries;
            plan_locked <= c_locked;
            plan_sess   <= c_sess;
            plan_sacct  <= c_sacct;
            plan_rbal   <= c_rbal;
            plan_idx    <= rd_idx;
        end
    end

    // EXEC -> RESP boundary: commit session state and response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sess_q        <= 1'b0;
            rsp_status_q  <= ST_OK;
            rsp_balance_q <= '0;
        end else if (state_q == S_EXEC) begin
            sess_q        <= plan_sess;
            rsp_status_q  <= plan_status;
            rsp_balance_q <= plan_rbal;
        end
    end

    // Session account follows the committed session
    always_ff @(posedge clk) begin
        if (state_q == S_EXEC) sess_acct_q <= plan_sacct;
    end

endmodule
